// File: rtl/seg_pkg.sv
// seg_pkg: shared types and widths for the seven-segment display sharing logic.
package seg_pkg;
    typedef enum logic [1:0] {ARB, GRANT, HOLD} state_t;
    localparam int DIGITS = 8;
    localparam int NIB_W = 4;
    localparam int DP_W = 3;
    localparam int DATA_W = DIGITS * NIB_W;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or above ptr (mod N) wins.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] gnt,
    output logic [1:0]   idx
);
    always_comb begin
        idx = '0;
        // scanning downward lets the closest requester to ptr overwrite the others
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) idx = 2'((int'(ptr) + k) % N);
        end
        gnt = N'(|req) << idx;
    end
endmodule

// File: rtl/seg_disp_arb.sv
// seg_disp_arb: round-robin arbiter with minimum dwell sharing the 8-digit display.
// Define SEG_DISP_ARB_IDLE_BLANK_EN to blank the digits after IDLE_TIMEOUT idle ARB cycles.
import seg_pkg::*;
module seg_disp_arb #(
    parameter int N_REQ = 2,
    parameter int HOLD_CYCLES = 1000,
    parameter int IDLE_TIMEOUT = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_data,
    input  logic [N_REQ*DP_W-1:0] req_dp,
    input  logic [N_REQ*8-1:0]    req_en,
    output logic [N_REQ-1:0]      ack,
    output logic [DATA_W-1:0]     disp_data,
    output logic [DP_W-1:0]       disp_dp,
    output logic [DIGITS-1:0]     disp_en,
    output logic [1:0]            owner,
    output logic                  busy
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    state_t state, state_nxt;
    logic [1:0] rr_ptr, idx;
    logic [N_REQ-1:0] gnt;
    logic [HW-1:0] hold_cnt;
    logic take;
    rr_pick #(.N(N_REQ)) u_pick (.req(req_valid), .ptr(rr_ptr), .gnt(gnt), .idx(idx));
    assign take = (state == ARB) && (|req_valid);
    assign busy = (state != ARB);
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     state_nxt = take ? GRANT : ARB;
            GRANT:   state_nxt = HOLD;
            HOLD:    state_nxt = (hold_cnt == HW'(HOLD_CYCLES - 1)) ? ARB : HOLD;
            default: state_nxt = ARB;
        endcase
    end
`ifdef SEG_DISP_ARB_IDLE_BLANK_EN
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    logic idle_hit;
    assign idle_hit = (state == ARB) && !take && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idle_cnt <= '0;
        else if (take) idle_cnt <= '0;
        else if (state == ARB && idle_cnt != IW'(IDLE_TIMEOUT)) idle_cnt <= idle_cnt + 1'b1;
    end
`else
    logic idle_hit;
    assign idle_hit = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            ack       <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
            owner     <= '0;
        end else begin
            state    <= state_nxt;
            ack      <= take ? gnt : '0;
            hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
            if (take) begin
                rr_ptr    <= (idx == 2'(N_REQ - 1)) ? 2'd0 : idx + 2'd1;
                owner     <= idx;
                disp_data <= req_data[32*int'(idx) +: 32];
                disp_dp   <= req_dp[DP_W*int'(idx) +: DP_W];
                disp_en   <= req_en[8*int'(idx) +: 8];
            end else if (idle_hit) begin
                disp_en <= '0;
            end
        end
    end
endmodule

// File: tb/tb_seg_disp_arb.sv
// tb_seg_disp_arb: directed stimulus with a grant scoreboard for seg_disp_arb (N_REQ=2, HOLD_CYCLES=4).
module tb_seg_disp_arb;
    localparam int HOLD = 4;
    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
        logic [2:0]  dp;
        logic [7:0]  en;
    } exp_t;
    logic clk = 0, rst = 1;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [5:0]  req_dp = '0;
    logic [15:0] req_en = '0;
    logic [1:0]  ack, owner;
    logic [31:0] disp_data;
    logic [2:0]  disp_dp;
    logic [7:0]  disp_en;
    logic        busy;
    int total = 0, bad = 0;
    exp_t sbq[$];
    seg_disp_arb #(.N_REQ(2), .HOLD_CYCLES(HOLD), .IDLE_TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_dp(req_dp),
        .req_en(req_en), .ack(ack), .disp_data(disp_data), .disp_dp(disp_dp),
        .disp_en(disp_en), .owner(owner), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input int i, input logic [31:0] d, input logic [2:0] dp, input logic [7:0] en, input bit push);
        exp_t e;
        req_data[32*i +: 32] = d;
        req_dp[3*i +: 3] = dp;
        req_en[8*i +: 8] = en;
        req_valid[i] = 1'b1;
        e.owner = 2'(i); e.data = d; e.dp = dp; e.en = en;
        if (push) sbq.push_back(e);
    endtask
    task automatic expect_grant(input string tag, input int maxc, output int cyc);
        exp_t e;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ack == 2'b00 && cyc < maxc);
        chk({tag, "_seen"}, 64'(ack != 2'b00), 64'd1);
        if (ack != 2'b00) begin
            chk({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({tag, "_ack"}, 64'(ack), 64'(2'b01 << e.owner));
                chk({tag, "_owner"}, 64'(owner), 64'(e.owner));
                chk({tag, "_data"}, 64'(disp_data), 64'(e.data));
                chk({tag, "_dp"}, 64'(disp_dp), 64'(e.dp));
                chk({tag, "_en"}, 64'(disp_en), 64'(e.en));
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask
    initial begin
        int c, n, acks;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_en", 64'(disp_en), 64'd0);
        chk("rst_data", 64'(disp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        rst = 0;
        repeat (10) @(negedge clk);
        chk("idle10_busy", 64'(busy), 64'd0);
        chk("idle10_ack", 64'(ack), 64'd0);
        // single request
        drive(0, 32'h12345678, 3'd3, 8'hFF, 1);
        expect_grant("single", 5, c);
        chk("single_latency", 64'(c), 64'd1);
        req_valid = '0;
        n = 1;
        @(negedge clk);
        chk("single_ack_pulse", 64'(ack), 64'd0);
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("single_busy_len", 64'(n), 64'(HOLD + 1));
        // both requesting continuously; pointer now at 1
        sbq.push_back('{2'd1, 32'hB1B1B1B1, 3'd1, 8'hAA});
        sbq.push_back('{2'd0, 32'hA0A0A0A0, 3'd0, 8'h55});
        sbq.push_back('{2'd1, 32'hB1B1B1B1, 3'd1, 8'hAA});
        sbq.push_back('{2'd0, 32'hA0A0A0A0, 3'd0, 8'h55});
        drive(0, 32'hA0A0A0A0, 3'd0, 8'h55, 0);
        drive(1, 32'hB1B1B1B1, 3'd1, 8'hAA, 0);
        expect_grant("rr0", 5, c);
        chk("rr0_latency", 64'(c), 64'd1);
        for (int g = 1; g < 4; g++) begin
            expect_grant($sformatf("rr%0d", g), 20, c);
            chk($sformatf("rr%0d_period", g), 64'(c), 64'(HOLD + 2));
        end
        req_valid = '0;
        wait_idle();
        // req1 raised and dropped while req0 holds the display
        drive(0, 32'h0000CAFE, 3'd7, 8'h0F, 1);
        expect_grant("hold", 5, c);
        req_valid = '0;
        @(negedge clk);
        drive(1, 32'hDEADBEEF, 3'd5, 8'hFF, 0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        acks = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack != 2'b00) acks++;
        end
        chk("drop_no_ack", 64'(acks), 64'd0);
        chk("drop_data", 64'(disp_data), 64'h0000CAFE);
        chk("drop_en", 64'(disp_en), 64'h0F);
        chk("drop_dp", 64'(disp_dp), 64'd7);
        chk("drop_owner", 64'(owner), 64'd0);
        // reset in the middle of HOLD; pointer would otherwise be 1
        drive(0, 32'h5555AAAA, 3'd2, 8'hF0, 1);
        expect_grant("prerst", 5, c);
        req_valid = '0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_ack", 64'(ack), 64'd0);
        chk("arst_data", 64'(disp_data), 64'd0);
        chk("arst_en", 64'(disp_en), 64'd0);
        chk("arst_dp", 64'(disp_dp), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 0;
        drive(0, 32'h11112222, 3'd4, 8'hC3, 1);
        drive(1, 32'h33334444, 3'd6, 8'h3C, 0);
        expect_grant("postrst", 5, c);
        chk("postrst_latency", 64'(c), 64'd1);
        req_valid = '0;
        wait_idle();
        // long idle in ARB
        repeat (25) @(negedge clk);
`ifdef SEG_DISP_ARB_IDLE_BLANK_EN
        chk("idle_en_blank", 64'(disp_en), 64'h00);
`else
        chk("idle_en_kept", 64'(disp_en), 64'hC3);
`endif
        chk("idle_data_kept", 64'(disp_data), 64'h11112222);
        chk("idle_dp_kept", 64'(disp_dp), 64'd4);
        drive(1, 32'h9876ABCD, 3'd1, 8'h7E, 1);
        expect_grant("reenable", 5, c);
        req_valid = '0;
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
